instr_fetch: RTL

Instruction fetch stage for the simple CPU: holds a small writable program memory and a program counter, and drives the 20-bit `instr` bus into the control unit. Each instruction is held stable for exactly the number of clock edges the control unit's FSM spends on that instruction class, then the next word is presented. Encoding `instr[19:18]==2'b00` is the HALT/idle class: the block parks and drives zero.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/instr_rom.sv | 23 ++
 rtl/instr_fetch.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction class codes, per-class hold lengths,
// and the fetch-stage state encoding.
package cpu_pkg;

  localparam logic [1:0] CLS_HALT  = 2'b00;
  localparam logic [1:0] CLS_STD   = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  localparam logic [2:0] LEN_STD = 3'd3;
  localparam logic [2:0] LEN_MEM = 3'd4;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_t;

  // Number of edges the control unit spends on one instruction of class cls.
  function automatic logic [2:0] hold_len(input logic [1:0] cls);
    case (cls)
      CLS_LOAD, CLS_STORE: hold_len = LEN_MEM;
      default:             hold_len = LEN_STD;
    endcase
  endfunction

endpackage

// File: rtl/instr_rom.sv
// Writable program memory: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module instr_rom #(
  parameter int INSTR_WIDTH = 20,
  parameter int ADDR_BITS   = 5
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_BITS-1:0]   waddr,
  input  logic [INSTR_WIDTH-1:0] wdata,
  input  logic [ADDR_BITS-1:0]   raddr,
  output logic [INSTR_WIDTH-1:0] rdata
);

  logic [INSTR_WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: presents each program word on instr for exactly as
// many edges as the control unit needs for its class, then advances the PC.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int INSTR_WIDTH = 20,
  parameter int ADDR_BITS   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   load_we,
  input  logic [ADDR_BITS-1:0]   load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_BITS-1:0]   pc,
  output logic                   fetch_strobe,
  output logic                   halted
);

  fetch_state_t           state, state_n;
  logic [INSTR_WIDTH-1:0] instr_n;
  logic [ADDR_BITS-1:0]   pc_n;
  logic [2:0]             cnt, cnt_n;
  logic                   strobe_n;
  logic                   rom_we;
  logic [INSTR_WIDTH-1:0] word;
  logic [1:0]             word_cls;

  instr_rom #(
    .INSTR_WIDTH(INSTR_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_rom (
    .clk  (clk),
    .we   (rom_we),
    .waddr(load_addr),
    .wdata(load_data),
    .raddr(pc),
    .rdata(word)
  );

  assign word_cls = word[INSTR_WIDTH-1 -: 2];
  assign halted   = (state == FS_HALT);

  // Async reset clears instr at once so the control unit sees class 00 immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FS_IDLE;
      instr        <= '0;
      pc           <= '0;
      cnt          <= '0;
      fetch_strobe <= 1'b0;
    end else begin
      state        <= state_n;
      instr        <= instr_n;
      pc           <= pc_n;
      cnt          <= cnt_n;
      fetch_strobe <= strobe_n;
    end
  end

  always_comb begin
    state_n  = state;
    instr_n  = instr;
    pc_n     = pc;
    cnt_n    = cnt;
    strobe_n = 1'b0;
    rom_we   = 1'b0;
    case (state)
      FS_IDLE: begin
        instr_n = '0;
        pc_n    = '0;
        if (load_we) begin
          rom_we = 1'b1;
        end else if (start) begin
          if (word_cls == CLS_HALT) begin
            state_n = FS_HALT;
          end else begin
            // Extra edge covers the control unit's RESET->DECODE step.
            instr_n  = word;
            pc_n     = pc + 1'b1;
            cnt_n    = hold_len(word_cls) + 3'd1;
            strobe_n = 1'b1;
            state_n  = FS_RUN;
          end
        end
      end
      FS_RUN: begin
        if (cnt > 3'd1) begin
          cnt_n = cnt - 3'd1;
        end else if (word_cls == CLS_HALT) begin
          instr_n = '0;
          cnt_n   = '0;
          state_n = FS_HALT;
        end else begin
          instr_n  = word;
          pc_n     = pc + 1'b1;
          cnt_n    = hold_len(word_cls);
          strobe_n = 1'b1;
        end
      end
      FS_HALT: begin
        instr_n = '0;
        if (load_we) begin
          rom_we = 1'b1;
        end else if (start) begin
          pc_n    = '0;
          state_n = FS_IDLE;
        end
      end
      default: begin
        instr_n = '0;
        pc_n    = '0;
        cnt_n   = '0;
        state_n = FS_IDLE;
      end
    endcase
  end

endmodule
